// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcode constants, ALU op / branch-condition encodings,
//            ALUCtl field positions and the R/I-type funct3 decode helper.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ALU operation encoding (ALUCtl[3:0]); 13..15 all mean NOP
  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_XOR   = 4'd3,
    ALU_SLL   = 4'd4,
    ALU_SRL   = 4'd5,
    ALU_SUB   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSA = 4'd10,
    ALU_PASSB = 4'd11,
    ALU_ANDN  = 4'd12,
    ALU_NOP   = 4'd13
  } alu_op_e;

  // Branch condition encoding (ALUCtl[6:4]); 0 and 7 both mean "none"
  typedef enum logic [2:0] {
    COND_NONE     = 3'd0,
    COND_EQ       = 3'd1,
    COND_NE       = 3'd2,
    COND_LT       = 3'd3,
    COND_GE       = 3'd4,
    COND_LTU      = 3'd5,
    COND_GEU      = 3'd6,
    COND_NONE_ALT = 3'd7
  } alu_cond_e;

  // ALUCtl field positions
  localparam int CTL_W        = 7;
  localparam int CTL_OP_LSB   = 0;
  localparam int CTL_OP_W     = 4;
  localparam int CTL_COND_LSB = 4;
  localparam int CTL_COND_W   = 3;

  // funct3 decode shared by OP and OP-IMM; i_alt selects SUB/SRA
  function automatic alu_op_e arith_op(input logic [2:0] i_f3, input logic i_alt);
    alu_op_e w_op;
    case (i_f3)
      3'b000:  w_op = i_alt ? ALU_SUB : ALU_ADD;
      3'b001:  w_op = ALU_SLL;
      3'b010:  w_op = ALU_SLT;
      3'b011:  w_op = ALU_SLTU;
      3'b100:  w_op = ALU_XOR;
      3'b101:  w_op = i_alt ? ALU_SRA : ALU_SRL;
      3'b110:  w_op = ALU_OR;
      default: w_op = ALU_AND;
    endcase
    return w_op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode
// Purpose  : Combinational decode of {opcode, funct} into ALU op and branch
//            condition. Macro ALU_CSR_EN enables SYSTEM/CSR op decode.
// Revision : 1.0  initial release
// ============================================================================
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [3:0] i_func,
  output alu_op_e    o_op,
  output alu_cond_e  o_cond
);

  logic [2:0] w_f3;
  logic       w_alt;

  assign w_f3  = i_func[2:0];
  assign w_alt = i_func[3];

  // Opcode/funct decode; unknown opcodes fall through to NOP, no condition
  always_comb begin
    o_op   = ALU_NOP;
    o_cond = COND_NONE;
    case (i_opcode)
      OPC_OP:    o_op = arith_op(w_f3, w_alt);
      // Immediate forms have no SUB; bit 3 only distinguishes SRAI from SRLI
      OPC_OPIMM: o_op = arith_op(w_f3, w_alt & (w_f3 == 3'b101));
      OPC_BRANCH: begin
        o_op = ALU_SUB;
        case (w_f3)
          3'b000:  o_cond = COND_EQ;
          3'b001:  o_cond = COND_NE;
          3'b100:  o_cond = COND_LT;
          3'b101:  o_cond = COND_GE;
          3'b110:  o_cond = COND_LTU;
          3'b111:  o_cond = COND_GEU;
          default: o_cond = COND_NONE;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_AUIPC: o_op = ALU_ADD;
      OPC_LUI:   o_op = ALU_PASSB;
`ifdef ALU_CSR_EN
      // CSR register and immediate forms share the low two funct3 bits
      OPC_SYSTEM: begin
        case (w_f3[1:0])
          2'b01:   o_op = ALU_PASSA;
          2'b10:   o_op = ALU_OR;
          2'b11:   o_op = ALU_ANDN;
          default: o_op = ALU_NOP;
        endcase
      end
`endif
      default:   o_op = ALU_NOP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module   : alu_control
// Purpose  : Decoded ALU with branch compare and registered outputs
//            (1-cycle latency). Macro ALU_CSR_EN enables CSR ops (ANDN).
// Revision : 1.0  initial release
// ============================================================================
module alu_control #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      Opcode,
  input  logic [3:0]      FuncCode,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] ALUOut,
  output logic            Branch_Enable,
  output logic [6:0]      ALUCtl
);
  import alu_pkg::*;

  alu_op_e         w_op;
  alu_cond_e       w_cond;
  logic [4:0]      w_shamt;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic [XLEN-1:0] w_result;
  logic            w_branch;
  logic [6:0]      w_ctl;

  logic [XLEN-1:0] r_alu_out;
  logic            r_branch;
  logic [6:0]      r_ctl;

  alu_decode u_decode (
    .i_opcode (Opcode),
    .i_func   (FuncCode),
    .o_op     (w_op),
    .o_cond   (w_cond)
  );

  assign w_shamt = B[4:0];
  assign w_eq    = (A == B);
  assign w_lt    = ($signed(A) < $signed(B));
  assign w_ltu   = (A < B);

  assign w_ctl[CTL_OP_LSB   +: CTL_OP_W]   = w_op;
  assign w_ctl[CTL_COND_LSB +: CTL_COND_W] = w_cond;

  // Datapath: result for the decoded op; NOP and unused codes give 0
  always_comb begin
    w_result = '0;
    case (w_op)
      ALU_AND:   w_result = A & B;
      ALU_OR:    w_result = A | B;
      ALU_ADD:   w_result = A + B;
      ALU_XOR:   w_result = A ^ B;
      ALU_SLL:   w_result = A << w_shamt;
      ALU_SRL:   w_result = A >> w_shamt;
      ALU_SUB:   w_result = A - B;
      ALU_SRA:   w_result = $unsigned($signed(A) >>> w_shamt);
      ALU_SLT:   w_result = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLTU:  w_result = {{(XLEN-1){1'b0}}, w_ltu};
      ALU_PASSA: w_result = A;
      ALU_PASSB: w_result = B;
`ifdef ALU_CSR_EN
      ALU_ANDN:  w_result = A & ~B;
`endif
      default:   w_result = '0;
    endcase
  end

  // Branch compare: GE is the complement of LT, so equal operands take GE
  always_comb begin
    w_branch = 1'b0;
    case (w_cond)
      COND_EQ:  w_branch = w_eq;
      COND_NE:  w_branch = ~w_eq;
      COND_LT:  w_branch = w_lt;
      COND_GE:  w_branch = ~w_lt;
      COND_LTU: w_branch = w_ltu;
      COND_GEU: w_branch = ~w_ltu;
      default:  w_branch = 1'b0;
    endcase
  end

  // Output registers; async reset clears everything and drops any pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out <= '0;
      r_branch  <= 1'b0;
      r_ctl     <= '0;
    end else begin
      r_alu_out <= w_result;
      r_branch  <= w_branch;
      r_ctl     <= w_ctl;
    end
  end

  assign ALUOut        = r_alu_out;
  assign Branch_Enable = r_branch;
  assign ALUCtl        = r_ctl;

endmodule
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control
// Purpose  : Self-checking bench for alu_control with a mnemonic-level
//            reference model. Honours ALU_CSR_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  Opcode;
  logic [3:0]  FuncCode;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUOut;
  logic        Branch_Enable;
  logic [6:0]  ALUCtl;

  int checks   = 0;
  int failures = 0;

  string OP_NAMES[14]  = '{"AND","OR","ADD","XOR","SLL","SRL","SUB","SRA",
                           "SLT","SLTU","PASSA","PASSB","ANDN","NOP"};
  string CND_NAMES[7]  = '{"NONE","EQ","NE","LT","GE","LTU","GEU"};

  alu_control #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Opcode        (Opcode),
    .FuncCode      (FuncCode),
    .A             (A),
    .B             (B),
    .ALUOut        (ALUOut),
    .Branch_Enable (Branch_Enable),
    .ALUCtl        (ALUCtl)
  );

  always #5 clk = ~clk;

  // Reference model: instruction -> mnemonic -> arithmetic result
  function automatic void model(input logic [6:0] opc, input logic [3:0] fc,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic br,
                                output logic [6:0] ctl);
    string  m  = "NOP";
    string  c  = "NONE";
    int     f3 = int'(fc[2:0]);
    bit     alt = fc[3];
    longint ua = longint'(a);
    longint ub = longint'(b);
    int     sa = int'(a);
    int     sb = int'(b);
    int     sh = int'(b[4:0]);
    int     opi = 13;
    int     cdi = 0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      case (f3)
        0: m = (alt && opc == 7'b0110011) ? "SUB" : "ADD";
        1: m = "SLL";
        2: m = "SLT";
        3: m = "SLTU";
        4: m = "XOR";
        5: m = alt ? "SRA" : "SRL";
        6: m = "OR";
        default: m = "AND";
      endcase
    end else if (opc == 7'b1100011) begin
      m = "SUB";
      case (f3)
        0: c = "EQ";
        1: c = "NE";
        4: c = "LT";
        5: c = "GE";
        6: c = "LTU";
        7: c = "GEU";
        default: c = "NONE";
      endcase
    end else if (opc == 7'b0000011 || opc == 7'b0100011 || opc == 7'b1101111 ||
                 opc == 7'b1100111 || opc == 7'b0010111) begin
      m = "ADD";
    end else if (opc == 7'b0110111) begin
      m = "PASSB";
    end
`ifdef ALU_CSR_EN
    else if (opc == 7'b1110011) begin
      if (f3 == 1 || f3 == 5)      m = "PASSA";
      else if (f3 == 2 || f3 == 6) m = "OR";
      else if (f3 == 3 || f3 == 7) m = "ANDN";
    end
`endif

    res = 32'h0;
    if      (m == "AND")   res = a & b;
    else if (m == "OR")    res = a | b;
    else if (m == "ADD")   res = 32'(ua + ub);
    else if (m == "XOR")   res = a ^ b;
    else if (m == "SLL")   res = 32'(ua << sh);
    else if (m == "SRL")   res = a >> sh;
    else if (m == "SUB")   res = 32'(ua - ub);
    else if (m == "SRA")   res = a[31] ? ~((~a) >> sh) : (a >> sh);
    else if (m == "SLT")   res = (sa < sb) ? 32'd1 : 32'd0;
    else if (m == "SLTU")  res = (ua < ub) ? 32'd1 : 32'd0;
    else if (m == "PASSA") res = a;
    else if (m == "PASSB") res = b;
    else if (m == "ANDN")  res = a & ~b;

    br = 1'b0;
    if      (c == "EQ")  br = (ua == ub);
    else if (c == "NE")  br = (ua != ub);
    else if (c == "LT")  br = (sa <  sb);
    else if (c == "GE")  br = (sa >= sb);
    else if (c == "LTU") br = (ua <  ub);
    else if (c == "GEU") br = (ua >= ub);

    for (int i = 0; i < 14; i++) if (OP_NAMES[i] == m) opi = i;
    for (int i = 0; i < 7; i++)  if (CND_NAMES[i] == c) cdi = i;
    ctl = {3'(cdi), 4'(opi)};
  endfunction

  // Any NOP code (13..15) and either "none" condition (0/7) compare equal
  function automatic logic [6:0] norm_ctl(input logic [6:0] v);
    logic [3:0] o;
    logic [2:0] cc;
    o  = v[3:0];
    cc = v[6:4];
    if (o >= 4'd13)  o  = 4'd13;
    if (cc == 3'd7)  cc = 3'd0;
    return {cc, o};
  endfunction

  task automatic drive(input logic [6:0] o, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Opcode = o; FuncCode = f; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    Opcode = 7'b0110011; FuncCode = 4'b0110; A = 32'h1234; B = 32'h5678;
    #2;
    checks++; if (ALUOut !== 32'h0) begin failures++; $display("FAIL reset_aluout got %h want 00000000", ALUOut); end
    checks++; if (Branch_Enable !== 1'b0) begin failures++; $display("FAIL reset_branch got %b want 0", Branch_Enable); end
    checks++; if (ALUCtl !== 7'h0) begin failures++; $display("FAIL reset_ctl got %h want 00", ALUCtl); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ALUOut !== 32'h0) begin failures++; $display("FAIL reset_hold_aluout got %h want 00000000", ALUOut); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scenarios;
    drive(7'b0110011, 4'b0111, 32'h0F, 32'h55);
    checks++; if (ALUOut !== 32'h05) begin failures++; $display("FAIL and_out got %h want 00000005", ALUOut); end
    checks++; if (ALUCtl !== 7'h00) begin failures++; $display("FAIL and_ctl got %h want 00", ALUCtl); end
    drive(7'b0110011, 4'b0001, 32'd1, 32'd31);
    checks++; if (ALUOut !== 32'h80000000) begin failures++; $display("FAIL sll31 got %h want 80000000", ALUOut); end
    drive(7'b0110011, 4'b0001, 32'd2, 32'd16);
    checks++; if (ALUOut !== 32'h00020000) begin failures++; $display("FAIL sll16 got %h want 00020000", ALUOut); end
    drive(7'b0110011, 4'b1101, 32'hFFFFFFFF, 32'd2);
    checks++; if (ALUOut !== 32'hFFFFFFFF) begin failures++; $display("FAIL sra got %h want ffffffff", ALUOut); end
    drive(7'b0110011, 4'b1000, 32'd10000, 32'd111);
    checks++; if (ALUOut !== 32'd9889) begin failures++; $display("FAIL sub got %0d want 9889", ALUOut); end
    drive(7'b1100011, 4'b0100, 32'hFFFFFFFF, 32'd1);
    checks++; if (Branch_Enable !== 1'b1) begin failures++; $display("FAIL blt_neg got %b want 1", Branch_Enable); end
    checks++; if (ALUCtl !== 7'h36) begin failures++; $display("FAIL blt_ctl got %h want 36", ALUCtl); end
    drive(7'b1100011, 4'b0100, 32'd1, 32'd1);
    checks++; if (Branch_Enable !== 1'b0) begin failures++; $display("FAIL blt_eq got %b want 0", Branch_Enable); end
    drive(7'b1100011, 4'b0101, 32'd1, 32'd1);
    checks++; if (Branch_Enable !== 1'b1) begin failures++; $display("FAIL bge_eq got %b want 1", Branch_Enable); end
    drive(7'b1100011, 4'b0101, 32'd1, 32'd2);
    checks++; if (Branch_Enable !== 1'b0) begin failures++; $display("FAIL bge_lt got %b want 0", Branch_Enable); end
    drive(7'b1110011, 4'b0110, 32'h0F, 32'h55);
`ifdef ALU_CSR_EN
    checks++; if (ALUOut !== 32'h5F) begin failures++; $display("FAIL csrrsi got %h want 0000005f", ALUOut); end
`else
    checks++; if (ALUOut !== 32'h0) begin failures++; $display("FAIL system_nop got %h want 00000000", ALUOut); end
`endif
    drive(7'b0000000, 4'b0000, 32'hDEADBEEF, 32'hDEADBEEF);
    checks++; if (ALUOut !== 32'h0) begin failures++; $display("FAIL unknown_out got %h want 00000000", ALUOut); end
    checks++; if (Branch_Enable !== 1'b0) begin failures++; $display("FAIL unknown_br got %b want 0", Branch_Enable); end
  endtask

  // Back-to-back randomized instructions, one per cycle
  task automatic test_back_to_back;
    logic [6:0]  opcs[11] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011,
                              7'b0100011, 7'b1101111, 7'b1100111, 7'b0010111,
                              7'b0110111, 7'b1110011, 7'b0000000};
    logic [31:0] edges[5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};
    logic [6:0]  o;
    logic [3:0]  f;
    logic [31:0] a, b, er;
    logic        eb;
    logic [6:0]  ec;
    for (int i = 0; i < 400; i++) begin
      o = opcs[$urandom_range(0, 10)];
      if (o == 7'b0000000) o = 7'($urandom);
      f = 4'($urandom);
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = edges[$urandom_range(0, 4)];
        default: b = $urandom;
      endcase
      drive(o, f, a, b);
      model(o, f, a, b, er, eb, ec);
      checks++;
      if (ALUOut !== er) begin
        failures++;
        $display("FAIL rand_out[%0d] opc=%b fc=%b a=%h b=%h got %h want %h", i, o, f, a, b, ALUOut, er);
      end
      checks++;
      if (Branch_Enable !== eb) begin
        failures++;
        $display("FAIL rand_br[%0d] opc=%b fc=%b a=%h b=%h got %b want %b", i, o, f, a, b, Branch_Enable, eb);
      end
      checks++;
      if (norm_ctl(ALUCtl) !== ec) begin
        failures++;
        $display("FAIL rand_ctl[%0d] opc=%b fc=%b got %h want %h", i, o, f, ALUCtl, ec);
      end
    end
  endtask

  task automatic test_async_reset;
    drive(7'b0110011, 4'b0000, 32'd5, 32'd6);
    checks++; if (ALUOut !== 32'd11) begin failures++; $display("FAIL pre_reset got %0d want 11", ALUOut); end
    // Assert reset between edges: outputs must clear with no clock edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ALUOut !== 32'h0) begin failures++; $display("FAIL async_out got %h want 00000000", ALUOut); end
    checks++; if (ALUCtl !== 7'h0) begin failures++; $display("FAIL async_ctl got %h want 00", ALUCtl); end
    // Inputs presented while in reset must be discarded
    @(negedge clk);
    Opcode = 7'b1100011; FuncCode = 4'b0000; A = 32'd9; B = 32'd9;
    @(posedge clk);
    #1;
    checks++; if (Branch_Enable !== 1'b0) begin failures++; $display("FAIL held_br got %b want 0", Branch_Enable); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (Branch_Enable !== 1'b1) begin failures++; $display("FAIL first_capture_br got %b want 1", Branch_Enable); end
    // Pending instruction overtaken by reset before its capture edge
    @(negedge clk);
    Opcode = 7'b0110011; FuncCode = 4'b0000; A = 32'd7; B = 32'd8;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ALUOut !== 32'h0) begin failures++; $display("FAIL pending_discard got %h want 00000000", ALUOut); end
    @(negedge clk);
    rst_n = 1'b1;
    Opcode = 7'b0000000; FuncCode = 4'b0000; A = 32'd3; B = 32'd4;
    @(posedge clk);
    #1;
    checks++; if (ALUOut !== 32'h0) begin failures++; $display("FAIL post_reset_unknown got %h want 00000000", ALUOut); end
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
